// File: rtl/nano_mem_pkg.sv
// nano_mem_pkg: shared FSM state type, wait-state limit and parameter check for nano_mem_ctrl
package nano_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam int MAX_WAIT_STATES = 7;
  function automatic bit params_ok(int ws, int depth, int aw);
    return ws >= 0 && ws <= MAX_WAIT_STATES && depth >= 1 && longint'(depth) <= (longint'(1) << aw);
  endfunction
endpackage

// File: rtl/nano_mem_array.sv
// nano_mem_array: DEPTH x DATA_W storage, one sync write port, one registered read port returning 0 out of range
module nano_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic w_ok, r_ok;
  always_comb begin
    w_ok = 32'(waddr) < 32'(DEPTH);
    r_ok = 32'(raddr) < 32'(DEPTH);
  end
  always_ff @(posedge clk)
    if (we && w_ok) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= r_ok ? mem[raddr] : '0;
endmodule

// File: rtl/nano_mem_ctrl.sv
// nano_mem_ctrl: wait-state CPU memory with priority loader port and out-of-range error pulse
module nano_mem_ctrl
  import nano_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataW,
  output logic [DATA_W-1:0] dataR,
  output logic              ready,
  output logic              err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack
);
  if (!params_ok(WAIT_STATES, DEPTH, ADDR_W)) begin : g_bad_params
    $error("nano_mem_ctrl: WAIT_STATES or DEPTH out of range");
  end
  state_t            state, nxt;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] a_addr, mem_waddr;
  logic [DATA_W-1:0] a_data, mem_wdata;
  logic              a_we, mem_we, mem_re, oor, accept;
  always_comb begin
    accept    = state == IDLE && !ld_en && ce;
    oor       = 32'(a_addr) >= 32'(DEPTH);
    nxt       = state == IDLE ? (accept ? (WAIT_STATES == 0 ? ACCESS : WAIT) : IDLE) :
                state == WAIT ? (cnt == 3'd1 ? ACCESS : WAIT) : IDLE;
    mem_we    = !rst && ((state == IDLE && ld_en) || (state == ACCESS && a_we));
    mem_re    = state == ACCESS && !a_we;
    mem_waddr = state == IDLE ? ld_addr : a_addr;
    mem_wdata = state == IDLE ? ld_data : a_data;
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      err    <= 1'b0;
      ld_ack <= 1'b0;
    end else begin
      state  <= nxt;
      ready  <= state == ACCESS;
      err    <= state == ACCESS && oor;
      ld_ack <= state == IDLE && ld_en;
      if (accept) begin
        a_addr <= address;
        a_we   <= we;
        a_data <= dataW;
        cnt    <= 3'(WAIT_STATES);
      end else if (state == WAIT) cnt <= cnt - 3'd1;
    end
  end
  nano_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
    .clk(ck),
    .rst(rst),
    .we(mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re(mem_re),
    .raddr(a_addr),
    .rdata(dataR)
  );
endmodule

// File: doc/nano_mem_ctrl.md
# nano_mem_ctrl

Parametrised data/instruction memory for the NanoCPU with a wait-state handshake, a priority loader port and out-of-range detection. It replaces the zero-latency bench memory model with a synthesisable block that the CPU must handshake against. It sits between `NanoCPU` (address/dataR/dataW/ce/we) and an external program loader that fills memory before or between runs.

## Interface
- `DATA_W`, 16, word width
- `ADDR_W`, 8, address width
- `DEPTH`, 256, implemented words, 1..2**ADDR_W
- `WAIT_STATES`, 1, extra cycles per CPU access, 0..7
- `ck`  in  1  clock, single clock domain, rising edge
- `rst`  in  1  synchronous, active-high reset
- `ce`  in  1  CPU access request, held high until `ready`
- `we`  in  1  CPU write when 1, read when 0, sampled with `ce`
- `address`  in  ADDR_W  CPU word address
- `dataW`  in  DATA_W  CPU write data
- `dataR`  out  DATA_W  registered read data, valid while `ready`=1
- `ready`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse with `ready` when address >= DEPTH
- `ld_en`  in  1  loader write request
- `ld_addr`  in  ADDR_W  loader address
- `ld_data`  in  DATA_W  loader data
- `ld_ack`  out  1  one-cycle pulse, loader write committed

## Operation
- FSM states: IDLE, WAIT, ACCESS.
- IDLE: `ld_en`=1 → write `ld_data` to `ld_addr` on this edge, `ld_ack`=1 next cycle, stay IDLE. Else `ce`=1 → latch `address`, `we`, `dataW`, load wait counter with WAIT_STATES, go WAIT (ACCESS if WAIT_STATES=0).
- Loader has priority over CPU in IDLE; CPU keeps `ce` high and is accepted on the first IDLE edge with `ld_en`=0.
- `ld_en` outside IDLE is not serviced; it is held until IDLE, with no `ld_ack`.
- WAIT: the counter decrements each edge; on reaching 1, go ACCESS.
- ACCESS: on the edge leaving it, commit the latched write, or register the read word into `dataR`. Set `ready`=1 for the following cycle and return to IDLE.
- Out of range (latched address >= DEPTH): write suppressed, `dataR` = 0, `err`=1 with `ready`. A loader address >= DEPTH is ignored, but `ld_ack` still pulses.
- `ce` dropping after acceptance does not cancel the transaction.
- `dataR` holds its value until the next read completes; writes do not change `dataR`.
- Reset: state IDLE; counter 0; `ready`, `err`, `ld_ack` = 0; `dataR` = 0. Memory contents are NOT cleared.
- Reset mid-transaction aborts it: no write commits and no `ready` is issued.
- Reset has priority over `ld_en` on the same edge.

## Timing
- A request accepted at edge k gives `ready` high in the cycle after edge k+WAIT_STATES+1. Access latency is WAIT_STATES+2 cycles from the `ce` rising edge.
- Back-to-back: `ce` sampled high in the `ready` cycle is accepted at that edge, because the FSM is already IDLE. Throughput is one access per WAIT_STATES+2 cycles.
- Loader write throughput: one per cycle while IDLE.
- A read following a write to the same address returns the new data, because commits are ordered.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- `nano_mem_pkg`: FSM state enum typedef, `MAX_WAIT_STATES` = 7 constant, parameter-check helper.
- Sub-module `nano_mem_array`: DEPTH×DATA_W storage, one synchronous write port, one registered read port. The controller muxes the loader and CPU onto this single write port.
- Elaboration-time assertions: WAIT_STATES <= MAX_WAIT_STATES, and DEPTH <= 2**ADDR_W.

## Test plan
- WAIT_STATES=1: load `'h1111`@30 via loader, CPU read @30 → `ld_ack` 1 cycle later; `ready` 3 cycles after `ce`, `dataR`=`'h1111`, `err`=0.
- WAIT_STATES=0: CPU write `'h2222`@31 then back-to-back read @31 → `ready` every 2 cycles, read returns `'h2222`.
- `ld_en` and `ce` both high in IDLE (ld `'hAAAA`@5, CPU read @5) → `ld_ack` first, CPU accepted one edge later, `dataR`=`'hAAAA`.
- DEPTH=200, CPU write @250 then read @250 → `err`=1 with each `ready`, `dataR`=0, and no location in memory is modified.
- Write `'h00FF`@7 with WAIT_STATES=3, assert `rst` during WAIT → no `ready`, @7 keeps its old value, outputs are 0 the cycle after reset.
- Reset after loading `'h1234`@0 → read @0 after reset returns `'h1234`, confirming contents are preserved.
